lab_pio_out: RTL and testbench
==============================

LAB_PIO_OUT -- requirements
Module: lab_pio_out

Interface
REQ-001 Parameter WIDTH, default 8: output port width, legal range 1..32.
REQ-002 Parameter PERIOD_W, default 24: width of the blink period register and counter, legal range 1..32.
REQ-003 Parameter RESET_VALUE, default 0: DATA register value after reset, WIDTH bits.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data; zero wait states, combinational from registers.
REQ-011 out_port  output  WIDTH  driven pin value.

Function
REQ-012 A write SHALL occur when chipselect=1 and write_n=0 on a rising clk edge; writedata bits above WIDTH (or above PERIOD_W for PERIOD) are ignored.
REQ-013 Register map: 0 DATA (RW); 1 BLINK_MASK (RW); 2 PERIOD (RW); 3 STATUS (RO); 4 OUTSET (WO); 5 OUTCLEAR (WO); 6 OUTTOGGLE (WO); 7 reserved.
REQ-014 OUTSET SHALL apply DATA |= wd; OUTCLEAR SHALL apply DATA &= ~wd; OUTTOGGLE SHALL apply DATA ^= wd; each in one cycle.
REQ-015 readdata SHALL return DATA, BLINK_MASK, or PERIOD zero-extended to 32 bits at addresses 0-2; STATUS at address 3; 0 at addresses 4-7, independent of chipselect.
REQ-016 STATUS: bit0 = phase, bit1 = blink active (PERIOD != 0), bits 31:2 = 0.
REQ-017 out_port SHALL equal DATA XOR (BLINK_MASK AND {WIDTH{phase}}); a write at edge N SHALL be visible on out_port immediately after edge N.
REQ-018 The blink timer is IDLE when PERIOD = 0: counter held at 0, phase held at 0.
REQ-019 The blink timer is RUN when PERIOD != 0: counter increments each cycle; when counter = PERIOD, counter SHALL wrap to 0 and phase SHALL toggle, so phase half-period = PERIOD+1 cycles.
REQ-020 Any write to PERIOD SHALL clear counter and phase in the same cycle, including mid-count and writes of the current value.
REQ-021 A DATA-modifying write coinciding with a phase toggle SHALL apply both; out_port reflects both after that edge.
REQ-022 Writes to STATUS or address 7 SHALL have no effect.

Reset
REQ-023 While reset_n = 0 at a rising edge: DATA = RESET_VALUE, BLINK_MASK = 0, PERIOD = 0, counter = 0, phase = 0; therefore out_port = RESET_VALUE.
REQ-024 Reset SHALL override any simultaneous bus write, and it SHALL abort a running blink with no residual state.

Structure
REQ-025 Register address constants (DATA..OUTTOGGLE) and STATUS bit positions SHALL reside in shared package lab_pio_pkg.
REQ-026 The counter and phase logic SHALL be a sub-module lab_pio_blink_timer (inputs clk, reset_n, period, period_wr; output phase).

Verification (WIDTH=8, PERIOD_W=24, RESET_VALUE=0)
REQ-027 Write DATA=0xA5, then OUTSET 0x0F, OUTCLEAR 0xA0, OUTTOGGLE 0xFF -> out_port 0xA5, 0xAF, 0x0F, 0xF0 in successive cycles; a read of address 0 matches each value.
REQ-028 Write DATA=0xFFFFFF00 -> out_port 0x00 and readdata 0x00000000; a write with chipselect=0 -> no change.
REQ-029 Write DATA=0x00, BLINK_MASK=0x81, PERIOD=3 -> out_port alternates 0x00/0x81 every 4 cycles; STATUS reads 0x2 or 0x3 in step with the phase.
REQ-030 Write PERIOD=3 while phase=1 at counter=2 -> phase=0 and counter=0 the next cycle, and the next toggle occurs 4 cycles later; write PERIOD=0 -> out_port = DATA and STATUS = 0.
REQ-031 Assert reset_n=0 for one cycle while blinking with DATA=0x3C -> out_port=0x00 and all registers read 0 afterwards.
REQ-032 Issue an OUTTOGGLE 0x01 on the same edge as a phase toggle with BLINK_MASK=0x01 -> bit0 of out_port is unchanged (both inversions applied).

Source files
------------

// File: rtl/lab_pio_pkg.sv
// Shared register map and STATUS bit layout for the lab PIO output block.
package lab_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA       = 3'd0,
    ADDR_BLINK_MASK = 3'd1,
    ADDR_PERIOD     = 3'd2,
    ADDR_STATUS     = 3'd3,
    ADDR_OUTSET     = 3'd4,
    ADDR_OUTCLEAR   = 3'd5,
    ADDR_OUTTOGGLE  = 3'd6,
    ADDR_RSVD       = 3'd7
  } pio_addr_e;

  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

  function automatic logic [31:0] status_word(input logic phase, input logic active);
    logic [31:0] w;
    w = '0;
    w[STATUS_PHASE_BIT]  = phase;
    w[STATUS_ACTIVE_BIT] = active;
    return w;
  endfunction

endpackage

// File: rtl/lab_pio_blink_timer.sv
// Blink phase generator: counts 0..period, toggling phase on each wrap.
// period == 0 parks the timer; any period write restarts it from phase 0.
module lab_pio_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_wr,
  output logic                phase
);

  logic [PERIOD_W-1:0] r_count;
  logic                r_phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (period_wr || (period == '0)) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else if (r_count == period) begin
      r_count <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/lab_pio_out.sv
// Avalon-MM output PIO with set/clear/toggle aliases and a masked blink overlay.
module lab_pio_out
  import lab_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               PERIOD_W    = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mask;
  logic [PERIOD_W-1:0] r_period;

  logic                w_wr;
  logic                w_period_wr;
  logic                w_phase;
  logic                w_active;
  logic [WIDTH-1:0]    w_wd;
  logic [PERIOD_W-1:0] w_wp;
  logic                w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_wp        = writedata[PERIOD_W-1:0];
  assign w_active    = (r_period != '0);
  assign w_unused    = ^writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:       r_data   <= w_wd;
        ADDR_BLINK_MASK: r_mask   <= w_wd;
        ADDR_PERIOD:     r_period <= w_wp;
        ADDR_OUTSET:     r_data   <= r_data | w_wd;
        ADDR_OUTCLEAR:   r_data   <= r_data & ~w_wd;
        ADDR_OUTTOGGLE:  r_data   <= r_data ^ w_wd;
        default:         ;
      endcase
    end
  end

  lab_pio_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_blink_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .period    (r_period),
    .period_wr (w_period_wr),
    .phase     (w_phase)
  );

  // Read path ignores chipselect: zero-wait-state, purely decoded from address.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:       readdata = 32'(r_data);
      ADDR_BLINK_MASK: readdata = 32'(r_mask);
      ADDR_PERIOD:     readdata = 32'(r_period);
      ADDR_STATUS:     readdata = status_word(w_phase, w_active);
      default:         readdata = '0;
    endcase
  end

  assign out_port = r_data ^ (r_mask & {WIDTH{w_phase}});

endmodule

// File: tb/tb_lab_pio_out.sv
// Directed self-checking bench for lab_pio_out with a queue-based scoreboard.
module tb_lab_pio_out;
  import lab_pio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] q_out[$];
  logic [31:0] q_stat[$];

  lab_pio_out #(
    .WIDTH       (8),
    .PERIOD_W    (24),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_out(input string tag, output logic [31:0] e);
    if (q_out.size() == 0) begin
      e = '0;
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty out queue expected an entry", tag);
    end else begin
      e = q_out.pop_front();
      chk(tag, {24'b0, out_port}, e);
    end
  endtask

  task automatic pop_stat(input string tag);
    logic [31:0] e;
    if (q_stat.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty status queue expected an entry", tag);
    end else begin
      e = q_stat.pop_front();
      rd_chk(tag, ADDR_STATUS, e);
    end
  endtask

  logic [2:0]  op_addr [4];
  logic [31:0] op_data [4];
  logic [31:0] op_exp  [4];
  logic [31:0] e;
  logic        ph;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("reset_out", {24'b0, out_port}, 32'h0);
    for (int a = 0; a < 4; a++) rd_chk($sformatf("reset_rd%0d", a), 3'(a), 32'h0);

    // DATA write followed by set / clear / toggle aliases, one per cycle
    op_addr = '{ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR, ADDR_OUTTOGGLE};
    op_data = '{32'hA5, 32'h0F, 32'hA0, 32'hFF};
    op_exp  = '{32'hA5, 32'hAF, 32'h0F, 32'hF0};
    for (int i = 0; i < 4; i++) begin
      q_out.push_back(op_exp[i]);
      wr(op_addr[i], op_data[i]);
      pop_out($sformatf("alias_out[%0d]", i), e);
      rd_chk($sformatf("alias_rd[%0d]", i), ADDR_DATA, e);
    end

    q_out.push_back(32'h5A);
    wr(ADDR_DATA, 32'h5A);
    pop_out("data_5a", e);

    chipselect = 1'b0;
    write_n    = 1'b0;
    address    = ADDR_DATA;
    writedata  = 32'h00;
    idle();
    write_n = 1'b1;
    chk("cs0_no_write", {24'b0, out_port}, 32'h5A);

    wr(ADDR_STATUS, 32'h0);
    wr(ADDR_RSVD, 32'h0);
    chk("ro_wr_out", {24'b0, out_port}, 32'h5A);
    rd_chk("ro_wr_data", ADDR_DATA, 32'h5A);
    rd_chk("ro_wr_mask", ADDR_BLINK_MASK, 32'h0);
    rd_chk("ro_wr_status", ADDR_STATUS, 32'h0);

    q_out.push_back(32'h00);
    wr(ADDR_DATA, 32'hFFFF_FF00);
    pop_out("data_trunc_out", e);
    rd_chk("data_trunc_rd", ADDR_DATA, 32'h0);

    wr(ADDR_PERIOD, 32'hFF00_0000);
    rd_chk("period_trunc_rd", ADDR_PERIOD, 32'h0);
    rd_chk("period_trunc_status", ADDR_STATUS, 32'h0);
    rd_chk("rd_addr4", ADDR_OUTSET, 32'h0);

    // Blink with PERIOD=3: phase half-period of 4 cycles, sampled from the write edge on
    wr(ADDR_DATA, 32'h00);
    wr(ADDR_BLINK_MASK, 32'h81);
    rd_chk("mask_rd", ADDR_BLINK_MASK, 32'h81);
    for (int k = 0; k < 23; k++) begin
      ph = ((k / 4) % 2) == 1;
      q_out.push_back(ph ? 32'h81 : 32'h00);
      q_stat.push_back(ph ? 32'h3 : 32'h2);
    end
    wr(ADDR_PERIOD, 32'h3);
    rd_chk("period_rd", ADDR_PERIOD, 32'h3);
    for (int k = 0; k < 23; k++) begin
      if (k != 0) idle();
      pop_out($sformatf("blink_out[%0d]", k), e);
      pop_stat($sformatf("blink_status[%0d]", k));
    end

    // Now phase=1, counter=2: rewrite PERIOD=3 restarts from phase 0
    for (int k = 0; k < 5; k++) begin
      q_out.push_back(k == 4 ? 32'h81 : 32'h00);
      q_stat.push_back(k == 4 ? 32'h3 : 32'h2);
    end
    wr(ADDR_PERIOD, 32'h3);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) idle();
      pop_out($sformatf("restart_out[%0d]", k), e);
      pop_stat($sformatf("restart_status[%0d]", k));
    end

    wr(ADDR_PERIOD, 32'h0);
    chk("stop_out", {24'b0, out_port}, 32'h00);
    rd_chk("stop_status", ADDR_STATUS, 32'h0);
    repeat (5) idle();
    chk("stop_hold_out", {24'b0, out_port}, 32'h00);
    rd_chk("stop_hold_status", ADDR_STATUS, 32'h0);

    // OUTTOGGLE coinciding with a phase toggle on the same bit
    wr(ADDR_BLINK_MASK, 32'h01);
    wr(ADDR_PERIOD, 32'h1);
    idle();
    chk("coinc_pre", {24'b0, out_port}, 32'h00);
    wr(ADDR_OUTTOGGLE, 32'h01);
    chk("coinc_out", {24'b0, out_port}, 32'h00);
    rd_chk("coinc_data", ADDR_DATA, 32'h01);
    rd_chk("coinc_status", ADDR_STATUS, 32'h3);
    idle();
    chk("coinc_hold", {24'b0, out_port}, 32'h00);
    idle();
    chk("coinc_next", {24'b0, out_port}, 32'h01);

    // Reset mid-blink with a simultaneous bus write
    wr(ADDR_DATA, 32'h3C);
    chk("pre_rst_out", {24'b0, out_port}, 32'h3C);
    idle();
    chk("pre_rst_blink", {24'b0, out_port}, 32'h3D);
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = ADDR_DATA;
    writedata  = 32'hFF;
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    chk("rst_out", {24'b0, out_port}, 32'h00);
    for (int a = 0; a < 4; a++) rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
    repeat (4) idle();
    chk("rst_hold_out", {24'b0, out_port}, 32'h00);
    rd_chk("rst_hold_status", ADDR_STATUS, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
